// File: rtl/demod_lpf.sv
// Per-channel accumulate-and-dump low-pass decimator (4 interleaved channels, AXI-Stream).
// Define DEMOD_LPF_SAT_EN to clamp the scaled sum to 32-bit range instead of wrapping.
module demod_lpf #(
    parameter int DECIM = 64,
    parameter int SHIFT = 6
) (
    input  logic        s_axis_aclk,
    input  logic        s_axis_areset,
    input  logic [31:0] s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    input  logic [1:0]  s_axis_tuser,
    output logic [31:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic [1:0]  m_axis_tuser
);
    localparam int AW = 32 + $clog2(DECIM);
    localparam int CW = $clog2(DECIM);
    localparam logic [CW-1:0] LAST = CW'(DECIM - 1);

    logic signed [AW-1:0] acc [4];
    logic [CW-1:0]        cnt [4];

    logic signed [AW-1:0] x_ext;
    logic signed [AW-1:0] sum;
    logic [31:0]          out_next;
    logic                 accept;
    logic                 is_dump;

    // Handshake: a beat transfers on a rising edge where valid & ready are both 1.
    // The input is stalled whenever the single output register is full and not
    // being drained this cycle; s_axis_tready never depends on s_axis_tvalid.
    assign s_axis_tready = !m_axis_tvalid || m_axis_tready;
    assign accept        = s_axis_tvalid && s_axis_tready;
    assign is_dump       = (cnt[s_axis_tuser] == LAST);

`ifdef DEMOD_LPF_SAT_EN
    localparam logic signed [AW-1:0] SAT_MAX = AW'(64'sh000000007FFFFFFF);
    localparam logic signed [AW-1:0] SAT_MIN = AW'(-64'sh0000000080000000);
    logic signed [AW-1:0] shifted;
`endif

    always_comb begin
        x_ext    = AW'(signed'(s_axis_tdata));
        sum      = acc[s_axis_tuser] + x_ext;
        out_next = '0;
`ifdef DEMOD_LPF_SAT_EN
        shifted  = sum >>> SHIFT;
        if (shifted > SAT_MAX) begin
            out_next = 32'h7FFFFFFF;
        end else if (shifted < SAT_MIN) begin
            out_next = 32'h80000000;
        end else begin
            out_next = shifted[31:0];
        end
`else
        // Floor rounding from the arithmetic shift; overflow wraps.
        out_next = 32'(sum >>> SHIFT);
`endif
    end

    always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
        if (s_axis_areset) begin
            for (int c = 0; c < 4; c++) begin
                acc[c] <= '0;
                cnt[c] <= '0;
            end
            m_axis_tdata  <= '0;
            m_axis_tuser  <= '0;
            m_axis_tvalid <= 1'b0;
        end else begin
            if (m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end
            if (accept) begin
                if (is_dump) begin
                    // A dump on the same edge as an output accept simply reloads.
                    m_axis_tdata        <= out_next;
                    m_axis_tuser        <= s_axis_tuser;
                    m_axis_tvalid       <= 1'b1;
                    acc[s_axis_tuser]   <= '0;
                    cnt[s_axis_tuser]   <= '0;
                end else begin
                    acc[s_axis_tuser]   <= sum;
                    cnt[s_axis_tuser]   <= cnt[s_axis_tuser] + CW'(1);
                end
            end
        end
    end

endmodule

// File: doc/demod_lpf.md
# demod_lpf

Per-channel accumulate-and-dump low-pass decimator for the sonar receive chain. Sits directly downstream of the sine demodulator and consumes its mixed 4-channel interleaved AXI-Stream (channel in `tuser`). Sums `DECIM` consecutive samples per channel, scales by `2^-SHIFT` and emits one baseband sample per channel per frame, removing the 2f mixing product and reducing the rate before the DMA and processing stages.

## Interface
- `DECIM`, 64: samples summed per channel per output; range 2..1024.
- `SHIFT`, 6: arithmetic right shift applied to the sum; range 0..`AW`-1.
- Derived `AW` = 32 + clog2(`DECIM`): accumulator width.

- `s_axis_aclk` in 1: single clock for all logic.
- `s_axis_areset` in 1: reset, asynchronous, active-high.
- `s_axis_tdata` in 32: signed mixed sample from the demodulator.
- `s_axis_tvalid` in 1: input valid.
- `s_axis_tready` out 1: input ready.
- `s_axis_tuser` in 2: channel index 0..3.
- `m_axis_tdata` out 32: signed filtered sample.
- `m_axis_tvalid` out 1: output valid.
- `m_axis_tready` in 1: downstream ready.
- `m_axis_tuser` out 2: channel index of the output sample.

## Operation
- Per channel c (0..3): accumulator `acc[c]` (signed, `AW` bits) and counter `cnt[c]` (0..`DECIM`-1).
- Accepted beat means `s_axis_tvalid & s_axis_tready`. Let c = `s_axis_tuser` and x = sign-extended `s_axis_tdata`.
- If `cnt[c]` < `DECIM`-1: `acc[c]` <= `acc[c]`+x and `cnt[c]` increments.
- If `cnt[c]` == `DECIM`-1 (dump): sum = `acc[c]`+x. Load the output register with (sum >>> `SHIFT`) narrowed to 32 bits, see Configuration. `m_axis_tuser` <= c and `m_axis_tvalid` <= 1. `acc[c]` <= 0 and `cnt[c]` <= 0.
- Channels are fully independent. Arbitrary interleaving is legal and carries no ordering requirement.
- Output register is a single stage. `s_axis_tready` = !`m_axis_tvalid` | `m_axis_tready`. The term is combinational, and there is no combinational path from `s_axis_tvalid`.
- `m_axis_tvalid` clears on `m_axis_tready` unless a new dump is accepted in the same cycle. In that case the register reloads and `m_axis_tvalid` stays 1.
- Once asserted, `m_axis_tvalid`, `m_axis_tdata` and `m_axis_tuser` hold stable until accepted.
- Rounding is floor, from the arithmetic shift. No rounding offset is added.

## Timing
- Reset (asynchronous, immediate): all `acc` = 0, all `cnt` = 0, `m_axis_tdata` = 0, `m_axis_tuser` = 0, `m_axis_tvalid` = 0.
- `s_axis_tready` is 1 while in reset and after release, because its value follows from `m_axis_tvalid` = 0.
- Reset asserted mid-frame discards partial sums and a pending output. The first frame after release needs a full `DECIM` beats per channel.
- Latency: the dump beat is accepted at edge N, and `m_axis_tvalid`=1 with valid data is visible after edge N.
- Throughput: 1 input beat/cycle while the output drains. With `m_axis_tready` low and output full, `s_axis_tready` is 0 and no state changes.
- A non-dump beat with the output full is also stalled. This is a deliberate simplification: the output rate is at most 1/`DECIM` of the input rate.
- Simultaneous output accept and dump on the same edge: the new sample replaces the old one, nothing is lost or duplicated.

## Configuration
- `DEMOD_LPF_SAT_EN` defined: (sum >>> `SHIFT`) is clamped to [-2^31, 2^31-1] before output.
- `DEMOD_LPF_SAT_EN` undefined: the low 32 bits are taken, and overflow wraps in two's complement.
- No overflow is possible when `SHIFT` >= clog2(`DECIM`) (the default), so the two builds are identical there.

## Test plan
- `DECIM`=4, `SHIFT`=2, ch0 inputs 100, 200, 300, 400, `m_axis_tready`=1 -> one output 250, `tuser`=0, valid 1 cycle after the 4th beat.
- Interleaved ch0..3 for 4 rounds: ch0 all 8, ch1 all -8, ch2 1,2,3,4, ch3 all 0 -> outputs in order 8, -8, 2, 0 with `tuser` 0, 1, 2, 3.
- Negative floor, `DECIM`=4, `SHIFT`=2: inputs -1, -1, -1, -2 -> output -2 (0xFFFFFFFE).
- Backpressure: hold `m_axis_tready`=0 after a dump -> `s_axis_tready`=0 and the output stays stable for 10 cycles. Release it -> the output is accepted once and input resumes with no lost beats.
- Saturation, `DECIM`=4, `SHIFT`=0, four 0x7FFFFFFF on ch1 -> 0x7FFFFFFF with `DEMOD_LPF_SAT_EN`, 0xFFFFFFFC without.
- Reset after 2 of 4 ch0 beats, then 4 beats of 40 -> output 40, and the pre-reset samples have no effect.
